multicycle_ctrl: RTL

//  Multi-cycle control FSM for the RV64I core: sequences fetch/decode/execute/mem/writeback around the

---
 rtl/multicycle_ctrl_if.sv | 34 +++
 rtl/multicycle_ctrl.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl_if.sv
// rtl/multicycle_ctrl_if.sv - shared memory port between the multi-cycle controller and memory
//
// Purpose: groups the single memory port request/response signals.
// Signals:
//   mem_req    request active (controller -> memory)
//   iord       0 = PC address (fetch), 1 = ALU address (data access)
//   mem_read   read qualifier
//   mem_write  write qualifier
//   mem_ready  memory completes the current request this cycle (memory -> controller)
// Modports: master = controller side, slave = memory side.

interface multicycle_ctrl_if;
    logic mem_req;
    logic iord;
    logic mem_read;
    logic mem_write;
    logic mem_ready;

    modport master (
        output mem_req,
        output iord,
        output mem_read,
        output mem_write,
        input  mem_ready
    );

    modport slave (
        input  mem_req,
        input  iord,
        input  mem_read,
        input  mem_write,
        output mem_ready
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multi-cycle control FSM for the RV64I core
//
// Purpose: sequences fetch/decode/execute/mem/writeback around the shared datapath,
// decodes the IR opcode, drives imm_gen select and datapath enables, and arbitrates
// the single memory port between fetch and data access with a bounded wait.
// Optional feature: define CTRL_PERF_EN to add the retired_cnt output (CNT_W bits).
// Ports:
//   clk, reset           clock / synchronous active-high reset
//   start, stop          begin fetching from IDLE / halt at next retire
//   instruction[31:0]    current IR contents
//   zero                 ALU zero flag for BEQ
//   mem                  memory port (multicycle_ctrl_if.master)
//   ir_write, pc_write   IR / PC load pulses
//   pc_src               0 = PC+4, 1 = branch target
//   alu_src_b            0 = rs2, 1 = imm
//   alu_op[1:0]          00 add, 01 sub, 10 R-funct, 11 I-funct
//   imm_sel[1:0]         00 I, 01 S, 10 B, 11 none
//   reg_write            regfile write pulse
//   mem_to_reg           writeback from memory data
//   busy, done           not IDLE / retire pulse
//   illegal, mem_err     sticky error flags, cleared by start
//   retired_cnt          retired-instruction count (CTRL_PERF_EN only)

module multicycle_ctrl #(
    parameter int MEM_WAIT_MAX = 15
`ifdef CTRL_PERF_EN
    ,
    parameter int CNT_W = 32
`endif
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        stop,
    input  logic [31:0] instruction,
    input  logic        zero,
    multicycle_ctrl_if.master mem,
    output logic        ir_write,
    output logic        pc_write,
    output logic        pc_src,
    output logic        alu_src_b,
    output logic [1:0]  alu_op,
    output logic [1:0]  imm_sel,
    output logic        reg_write,
    output logic        mem_to_reg,
    output logic        busy,
    output logic        done,
    output logic        illegal,
    output logic        mem_err
`ifdef CTRL_PERF_EN
    ,
    output logic [CNT_W-1:0] retired_cnt
`endif
);

    localparam int WAIT_W = $clog2(MEM_WAIT_MAX + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_WAIT_MAX);

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_SD  = 7'b0100011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    typedef enum logic [2:0] {
        st_idle,
        st_fetch,
        st_decode,
        st_exec,
        st_mem,
        st_wb
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [WAIT_W-1:0] wait_cnt;
    logic              stop_pending;
    logic              retire;
    logic              timeout;
    logic              set_illegal;
    logic              wait_hit;

    logic [6:0] opcode;
    logic       is_r;
    logic       is_i;
    logic       is_ld;
    logic       is_sd;
    logic       is_beq;
    logic       is_legal;

    // Only the opcode field steers control; the rest of the IR feeds the datapath.
    logic unused_ir_bits;
    assign unused_ir_bits = ^instruction[31:7];

    assign opcode   = instruction[6:0];
    assign is_r     = (opcode == OP_R);
    assign is_i     = (opcode == OP_I);
    assign is_ld    = (opcode == OP_LD);
    assign is_sd    = (opcode == OP_SD);
    assign is_beq   = (opcode == OP_BEQ);
    assign is_legal = is_r | is_i | is_ld | is_sd | is_beq;

    always_comb begin
        imm_sel = 2'b11;
        if (is_i || is_ld) begin
            imm_sel = 2'b00;
        end else if (is_sd) begin
            imm_sel = 2'b01;
        end else if (is_beq) begin
            imm_sel = 2'b10;
        end
    end

    // The counter sits at MEM_WAIT_MAX on the last allowed request cycle.
    assign wait_hit = (wait_cnt == WAIT_LAST);

    always_comb begin
        state_next    = state;
        mem.mem_req   = 1'b0;
        mem.iord      = 1'b0;
        mem.mem_read  = 1'b0;
        mem.mem_write = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_src        = 1'b0;
        alu_src_b     = 1'b0;
        alu_op        = 2'b00;
        reg_write     = 1'b0;
        mem_to_reg    = 1'b0;
        done          = 1'b0;
        retire        = 1'b0;
        timeout       = 1'b0;
        set_illegal   = 1'b0;
        busy          = (state != st_idle);

        case (state)
            st_idle: begin
                if (start) begin
                    state_next = st_fetch;
                end
            end
            st_fetch: begin
                mem.mem_req  = 1'b1;
                mem.mem_read = 1'b1;
                // mem_ready on the last wait cycle still completes normally.
                if (mem.mem_ready) begin
                    ir_write   = 1'b1;
                    pc_write   = 1'b1;
                    state_next = st_decode;
                end else if (wait_hit) begin
                    timeout    = 1'b1;
                    state_next = st_idle;
                end
            end
            st_decode: begin
                if (is_legal) begin
                    state_next = st_exec;
                end else begin
                    set_illegal = 1'b1;
                    state_next  = st_idle;
                end
            end
            st_exec: begin
                if (is_r) begin
                    alu_op     = 2'b10;
                    state_next = st_wb;
                end else if (is_i) begin
                    alu_op     = 2'b11;
                    alu_src_b  = 1'b1;
                    state_next = st_wb;
                end else if (is_ld || is_sd) begin
                    alu_src_b  = 1'b1;
                    state_next = st_mem;
                end else if (is_beq) begin
                    alu_op   = 2'b01;
                    pc_write = zero;
                    pc_src   = 1'b1;
                    retire   = 1'b1;
                end else begin
                    // IR changed under us after decode; treat as illegal.
                    set_illegal = 1'b1;
                    state_next  = st_idle;
                end
            end
            st_mem: begin
                mem.mem_req   = 1'b1;
                mem.iord      = 1'b1;
                mem.mem_read  = is_ld;
                mem.mem_write = is_sd;
                if (mem.mem_ready) begin
                    if (is_ld) begin
                        state_next = st_wb;
                    end else begin
                        retire = 1'b1;
                    end
                end else if (wait_hit) begin
                    timeout    = 1'b1;
                    state_next = st_idle;
                end
            end
            st_wb: begin
                reg_write  = 1'b1;
                mem_to_reg = is_ld;
                retire     = 1'b1;
            end
            default: begin
                state_next = st_idle;
            end
        endcase

        if (retire) begin
            done       = 1'b1;
            state_next = (stop || stop_pending) ? st_idle : st_fetch;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= st_idle;
            wait_cnt     <= '0;
            stop_pending <= 1'b0;
            illegal      <= 1'b0;
            mem_err      <= 1'b0;
        end else begin
            state <= state_next;

            // Only a waiting request stays in FETCH/MEM, so any other move restarts the count.
            if ((state_next == state) && ((state == st_fetch) || (state == st_mem))) begin
                wait_cnt <= wait_cnt + WAIT_W'(1);
            end else begin
                wait_cnt <= '0;
            end

            if (retire || (state_next == st_idle)) begin
                stop_pending <= 1'b0;
            end else if (stop && (state != st_idle)) begin
                stop_pending <= 1'b1;
            end

            if ((state == st_idle) && start) begin
                illegal <= 1'b0;
            end else if (set_illegal) begin
                illegal <= 1'b1;
            end

            if ((state == st_idle) && start) begin
                mem_err <= 1'b0;
            end else if (timeout) begin
                mem_err <= 1'b1;
            end
        end
    end

`ifdef CTRL_PERF_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            retired_cnt <= '0;
        end else if (done) begin
            retired_cnt <= retired_cnt + CNT_W'(1);
        end
    end
`endif

endmodule
